// File: rtl/tick_monitor.sv
// Watches a periodic tick stream, acquires lock after LOCK_N on-time intervals,
// and flags early ticks (err) or a clean end of stream from lock (done).
module tick_monitor #(
  parameter int PERIOD = 3,
  parameter int LOCK_N = 2,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  output logic          active,
  output logic          locked,
  output logic          err,
  output logic          done,
  output logic [CW-1:0] tick_count
);

  localparam int GW    = $clog2(PERIOD + 1);
  localparam int GOODW = $clog2(LOCK_N + 1);
  localparam logic [GW-1:0]    PER_G  = GW'(PERIOD);
  localparam logic [GOODW-1:0] LOCK_G = GOODW'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [GOODW-1:0]  good_q, good_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [CW-1:0]     count_q, count_d;
  logic              on_time, early, missing;

  always_comb begin
    // gap counts cycles since the last tick and parks at PERIOD once the tick is overdue
    gap_d = gap_q;
    if (tick) begin
      gap_d = GW'(1);
    end else if (gap_q >= PER_G) begin
      gap_d = PER_G;
    end else begin
      gap_d = gap_q + 1'b1;
    end

    on_time = tick && (gap_q == PER_G);
    early   = tick && (gap_q < PER_G);
    missing = !tick && (gap_q == PER_G);

    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    count_d = count_q + CW'(tick);

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = ACQ;
          good_d  = '0;
        end
      end
      ACQ: begin
        if (on_time) begin
          good_d = good_q + 1'b1;
          if (good_q + 1'b1 == LOCK_G) begin
            state_d = LOCKED;
          end
        end else if (early) begin
          good_d = '0;
          err_d  = 1'b1;
        end else if (missing) begin
          state_d = IDLE;
          good_d  = '0;
        end
      end
      LOCKED: begin
        if (early) begin
          state_d = ACQ;
          good_d  = '0;
          err_d   = 1'b1;
        end else if (missing) begin
          state_d = IDLE;
          good_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      good_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      good_q  <= good_d;
      err_q   <= err_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign active     = (state_q != IDLE);
  assign locked     = (state_q == LOCKED);
  assign err        = err_q;
  assign done       = done_q;
  assign tick_count = count_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Scoreboard bench for tick_monitor: a cycle-numbered reference model queues
// expected outputs, and a monitor compares them one cycle at a time.
module tb_tick_monitor;

  localparam int PERIOD = 3;
  localparam int LOCK_N = 2;
  localparam int CW     = 4;

  logic          clk;
  logic          reset;
  logic          tick;
  logic          active;
  logic          locked;
  logic          err;
  logic          done;
  logic [CW-1:0] tick_count;

  typedef struct packed {
    logic          active;
    logic          locked;
    logic          err;
    logic          done;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: phase 0 idle, 1 acquiring, 2 locked; intervals measured in absolute cycles
  int mPhase = 0;
  int mGood  = 0;
  int mCycle = 0;
  int mLast  = 0;
  int mCount = 0;

  tick_monitor #(.PERIOD(PERIOD), .LOCK_N(LOCK_N), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .active     (active),
    .locked     (locked),
    .err        (err),
    .done       (done),
    .tick_count (tick_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelStep(input bit t, output exp_t e);
    int since;
    since = mCycle - mLast;
    e = '0;
    case (mPhase)
      0: if (t) begin mPhase = 1; mGood = 0; end
      1: begin
        if (t && since == PERIOD) begin
          mGood++;
          if (mGood == LOCK_N) mPhase = 2;
        end else if (t) begin
          mGood = 0;
          e.err = 1'b1;
        end else if (since == PERIOD) begin
          mPhase = 0;
          mGood  = 0;
        end
      end
      default: begin
        if (t && since < PERIOD) begin
          mPhase = 1;
          mGood  = 0;
          e.err  = 1'b1;
        end else if (!t && since == PERIOD) begin
          mPhase = 0;
          mGood  = 0;
          e.done = 1'b1;
        end
      end
    endcase
    if (t) begin
      mLast  = mCycle;
      mCount = (mCount + 1) % (1 << CW);
    end
    mCycle++;
    e.active = (mPhase != 0);
    e.locked = (mPhase == 2);
    e.cnt    = CW'(mCount);
  endtask

  task automatic applyStimulus(input bit t);
    exp_t e;
    @(negedge clk);
    tick = t;
    modelStep(t, e);
    expQ.push_back(e);
  endtask

  task automatic pulses(input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      for (int j = 1; j < spacing; j++) applyStimulus(1'b0);
      applyStimulus(1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, ".active"}, int'(active), 0);
    checkOutput({tag, ".locked"}, int'(locked), 0);
    checkOutput({tag, ".err"}, int'(err), 0);
    checkOutput({tag, ".done"}, int'(done), 0);
    checkOutput({tag, ".tick_count"}, int'(tick_count), 0);
  endtask

  // Reset lands between edges; outputs must clear before any further clock edge
  task automatic asyncReset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b1;
    tick  = 1'b0;
    #1;
    checkCleared(tag);
    mPhase = 0;
    mGood  = 0;
    mCount = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("active", int'(active), int'(e.active));
        checkOutput("locked", int'(locked), int'(e.locked));
        checkOutput("err", int'(err), int'(e.err));
        checkOutput("done", int'(done), int'(e.done));
        checkOutput("tick_count", int'(tick_count), int'(e.cnt));
        checkOutput("err_done_exclusive", int'(err && done), 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b1;
    tick  = 1'b0;
    #12;
    checkCleared("reset");
    @(negedge clk);
    reset = 1'b0;

    // Lock on ticks 0,3,6,9 then let the stream end to get done
    pulses(1, 1);
    pulses(3, 3);
    idle(5);

    // Lock, one early tick, relock with two on-time ticks, then end
    pulses(3, 3);
    pulses(1, 2);
    pulses(2, 3);
    idle(6);

    // Tick held high for five cycles
    pulses(5, 1);
    idle(6);

    // Locked with tick_count 7, then async reset and reacquire
    asyncReset("fresh");
    pulses(7, 3);
    asyncReset("locked7");
    pulses(3, 3);
    idle(5);

    // Wrap tick_count through 16 and 17 ticks while locked
    asyncReset("prewrap");
    pulses(17, 3);
    idle(5);

    // Reset while err is high, then while done is high
    pulses(3, 3);
    pulses(1, 1);
    asyncReset("mid_err");
    idle(4);
    pulses(3, 3);
    idle(3);
    asyncReset("mid_done");
    idle(4);

    // Random spacing, biased toward on-time, with occasional resets
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) pulses(1, PERIOD);
      else pulses(1, $urandom_range(1, PERIOD + 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, PERIOD + 1));
      if ($urandom_range(0, 59) == 0) asyncReset("random");
    end
    idle(6);

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    checkOutput("drain", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
